muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit, parametrised in operand width, added beside the ALU in the execute stage of the core. It accepts one operation per start pulse and computes with a shift-add (multiply) or restoring shift-subtract (divide) datapath, one bit per cycle. While busy it stalls the core. It returns a registered result with a one-cycle done pulse.

---
 rtl/muldiv_unit_pkg.sv | 33 +++
 rtl/muldiv_unit_if.sv | 16 +
 rtl/muldiv_step.sv | 34 +++
 rtl/muldiv_unit.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
// Op encodings equal RV32M funct3 so decode can pass funct3 straight through.
package muldiv_unit_pkg;

  localparam int DATA_BUS = 32;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input muldiv_op_e op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage request/response bundle between the core and muldiv_unit.
interface muldiv_unit_if import muldiv_unit_pkg::*; #(
  parameter int WIDTH = DATA_BUS
);
  logic             start;
  muldiv_op_e       op;
  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] rs2;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, op, rs1, rs2, abort, input busy, done, result);
  modport slave  (input start, op, rs1, rs2, abort, output busy, done, result);
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {hi,lo} accumulator pair: shift-add for multiply
// (lo holds the multiplier), restoring trial-subtract for divide (hi=rem, lo=quot).
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opd_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   diff;

  always_comb begin
    addend = lo_i[0] ? opd_i : '0;
    sum    = {1'b0, hi_i} + {1'b0, addend};
    shl    = {hi_i, lo_i[WIDTH-1]};
    // Borrow out of the (WIDTH+1)-bit subtract means the trial failed.
    diff   = shl - {1'b0, opd_i};
    if (is_div) begin
      hi_o = diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: magnitudes in, one bit per cycle, sign fix at end.
// MULDIV_SPECIAL_BYPASS_EN: div-by-zero, signed overflow and zero-operand multiplies skip CALC.
module muldiv_unit import muldiv_unit_pkg::*; #(
  parameter  int WIDTH = DATA_BUS,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  muldiv_state_e      state_q, state_d;
  muldiv_op_e         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, opd_q, opd_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               neg_q, neg_d, dz_q, dz_d;

  logic [WIDTH-1:0]   step_hi, step_lo;
  logic               sgn_a, sgn_b, a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b, div_val;
  logic [2*WIDTH-1:0] prod;

`ifdef MULDIV_SPECIAL_BYPASS_EN
  logic               byp_q, byp_d;
  logic [WIDTH-1:0]   byp_res_q, byp_res_d;
  logic               special;
  logic [WIDTH-1:0]   special_res;

  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (op_is_div(bus.op)) begin
      if (bus.rs2 == '0) begin
        special     = 1'b1;
        special_res = op_is_rem(bus.op) ? bus.rs1 : '1;
      end else if (!bus.op[0] && bus.rs1 == {1'b1, {(WIDTH-1){1'b0}}} && bus.rs2 == '1) begin
        special     = 1'b1;
        special_res = op_is_rem(bus.op) ? '0 : bus.rs1;
      end
    end else if (bus.rs1 == '0 || bus.rs2 == '0) begin
      special = 1'b1;
    end
  end
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (op_is_div(op_q)),
    .hi_i   (hi_q),
    .lo_i   (lo_q),
    .opd_i  (opd_q),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

  // Operand decode at start; MUL low half is sign-agnostic so it runs unsigned.
  always_comb begin
    sgn_a = (bus.op == MD_MULH) || (bus.op == MD_MULHSU) ||
            (bus.op == MD_DIV)  || (bus.op == MD_REM);
    sgn_b = (bus.op == MD_MULH) || (bus.op == MD_DIV) || (bus.op == MD_REM);
    a_neg = sgn_a & bus.rs1[WIDTH-1];
    b_neg = sgn_b & bus.rs2[WIDTH-1];
    mag_a = a_neg ? -bus.rs1 : bus.rs1;
    mag_b = b_neg ? -bus.rs2 : bus.rs2;
  end

  always_comb begin
    prod    = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    div_val = op_is_rem(op_q) ? hi_q : lo_q;
    if (neg_q)
      div_val = -div_val;
    if (dz_q && !op_is_rem(op_q))
      div_val = '1;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opd_d    = opd_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    result_d = result_q;
`ifdef MULDIV_SPECIAL_BYPASS_EN
    byp_d     = byp_q;
    byp_res_d = byp_res_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start) begin
          op_d  = bus.op;
          hi_d  = '0;
          cnt_d = CNT_W'(WIDTH);
          dz_d  = op_is_div(bus.op) && (bus.rs2 == '0);
          if (op_is_div(bus.op)) begin
            lo_d  = mag_a;
            opd_d = mag_b;
            neg_d = op_is_rem(bus.op) ? a_neg : (a_neg ^ b_neg);
          end else begin
            lo_d  = mag_b;
            opd_d = mag_a;
            neg_d = a_neg ^ b_neg;
          end
`ifdef MULDIV_SPECIAL_BYPASS_EN
          byp_d     = special;
          byp_res_d = special_res;
          state_d   = special ? ST_FIX : ST_CALC;
`else
          state_d = ST_CALC;
`endif
        end
      end
      ST_CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1))
          state_d = ST_FIX;
      end
      ST_FIX: begin
        if (op_is_div(op_q))
          result_d = div_val;
        else if (op_q == MD_MUL)
          result_d = prod[WIDTH-1:0];
        else
          result_d = prod[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SPECIAL_BYPASS_EN
        if (byp_q)
          result_d = byp_res_q;
`endif
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush wins over everything, including a same-cycle start or a pending FIX write.
    if (bus.abort) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= MD_MUL;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opd_q    <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
`ifdef MULDIV_SPECIAL_BYPASS_EN
      byp_q     <= 1'b0;
      byp_res_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opd_q    <= opd_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      result_q <= result_d;
`ifdef MULDIV_SPECIAL_BYPASS_EN
      byp_q     <= byp_d;
      byp_res_q <= byp_res_d;
`endif
    end
  end

  assign bus.busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (WIDTH=32); drives and samples on the falling edge.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int LAT_FULL  = 34;
  localparam int BUSY_FULL = 33;
`ifdef MULDIV_SPECIAL_BYPASS_EN
  localparam int LAT_SP  = 2;
  localparam int BUSY_SP = 1;
`else
  localparam int LAT_SP  = LAT_FULL;
  localparam int BUSY_SP = BUSY_FULL;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Raise start for one cycle; returns at the falling edge of cycle 1.
  task automatic issue(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.rs1   = a;
    bus.rs2   = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int nbusy);
    lat   = 1;
    nbusy = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) nbusy++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done) n++;
    end
  endtask

  task automatic run_vec(input string tag, input muldiv_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit sp);
    int lat, nb;
    issue(op, a, b);
    wait_done(lat, nb);
    chk(tag, bus.result, exp);
    chk({tag, "_lat"}, 32'(lat), 32'(sp ? LAT_SP : LAT_FULL));
    chk({tag, "_busy"}, 32'(nb), 32'(sp ? BUSY_SP : BUSY_FULL));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int lat, nb, n;
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.op    = MD_MUL;
    bus.rs1   = '0;
    bus.rs2   = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_vec("mul",      MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
    run_vec("mul_big",  MD_MUL,    32'h00010000, 32'h00010000, 32'h00000000, 1'b0);
    run_vec("mulh",     MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
    run_vec("mulh_neg", MD_MULH,   32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 1'b0);
    run_vec("mulhu",    MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run_vec("mulhsu",   MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_vec("mul_zero", MD_MUL,    32'd0,        32'd5,        32'd0,        1'b1);
    run_vec("divu",     MD_DIVU,   32'd100,      32'd7,        32'd14,       1'b0);
    run_vec("remu",     MD_REMU,   32'd100,      32'd7,        32'd2,        1'b0);
    run_vec("div_neg",  MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
    run_vec("rem_neg",  MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
    run_vec("rem_negd", MD_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        1'b0);
    run_vec("divu_max", MD_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0);
    run_vec("remu_max", MD_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
    run_vec("div_z",    MD_DIV,    32'h00001234, 32'd0,        32'hFFFFFFFF, 1'b1);
    run_vec("rem_z",    MD_REM,    32'h00001234, 32'd0,        32'h00001234, 1'b1);
    run_vec("div_zn",   MD_DIV,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1'b1);
    run_vec("rem_zn",   MD_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b1);
    run_vec("divu_z",   MD_DIVU,   32'h00001234, 32'd0,        32'hFFFFFFFF, 1'b1);
    run_vec("div_ovf",  MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    run_vec("rem_ovf",  MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1);
    run_vec("remu_pre", MD_REMU,   32'd100,      32'd7,        32'd2,        1'b0);

    // Abort in cycle 10 of a DIVU, with a competing start in the same cycle.
    issue(MD_DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    bus.op    = MD_DIV;
    bus.rs1   = 32'd50;
    bus.rs2   = 32'd5;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    count_dones(40, n);
    chk("abort_nodone", 32'(n), 32'd0);
    chk("abort_result", bus.result, 32'd2);

    // Abort with start while idle: start must lose.
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("abort_idle_busy", 32'(bus.busy), 32'd0);

    // Back-to-back: second start raised in the DONE cycle of the first.
    issue(MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat, nb);
    chk("b2b_first", bus.result, 32'hFFFFFFFE);
    issue(MD_DIVU, 32'd100, 32'd7);
    chk("b2b_accept", 32'(bus.busy), 32'd1);
    wait_done(lat, nb);
    chk("b2b_lat", 32'(lat), 32'(LAT_FULL));
    chk("b2b_second", bus.result, 32'd14);
    @(negedge clk);

    // Start while busy is dropped: one done, original result.
    issue(MD_DIVU, 32'd1000, 32'd10);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = MD_MUL;
    bus.rs1   = 32'd3;
    bus.rs2   = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, nb);
    chk("busy_start_result", bus.result, 32'd100);
    count_dones(40, n);
    chk("busy_start_nodone", 32'(n), 32'd0);

    // Reset mid-CALC.
    issue(MD_MUL, 32'd7, 32'hFFFFFFFD);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    rst = 1'b0;
    count_dones(40, n);
    chk("midrst_nodone", 32'(n), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
